// File: rtl/regfile_writeback_if.sv
// Write-back bundle: execute/LSU results in, register-file write port and decode busy queries out.
interface regfile_writeback_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
);
  logic                  alu_valid;
  logic [ADDR_WIDTH-1:0] alu_rd;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  lsu_valid;
  logic                  lsu_ready;
  logic [ADDR_WIDTH-1:0] lsu_rd;
  logic [DATA_WIDTH-1:0] lsu_data;
  logic                  iss_valid;
  logic [ADDR_WIDTH-1:0] iss_rd;
  logic [ADDR_WIDTH-1:0] rs1;
  logic [ADDR_WIDTH-1:0] rs2;
  logic                  rs1_busy;
  logic                  rs2_busy;
  logic                  rf_wen;
  logic [ADDR_WIDTH-1:0] rf_rd;
  logic [DATA_WIDTH-1:0] rf_dataD;
  logic [31:0]           wb_count;

  modport master (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           iss_valid, iss_rd, rs1, rs2,
    output lsu_ready, rs1_busy, rs2_busy, rf_wen, rf_rd, rf_dataD, wb_count
  );

  modport slave (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
           iss_valid, iss_rd, rs1, rs2,
    input  lsu_ready, rs1_busy, rs2_busy, rf_wen, rf_rd, rf_dataD, wb_count
  );
endinterface

// File: rtl/regfile_writeback.sv
// Register-file write stage: ALU results take priority, LSU results wait in a one-entry buffer,
// and a busy scoreboard tracks registers with LSU results still outstanding.
module regfile_writeback #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_writeback_if.master  bus
);
  localparam int NREG = 1 << ADDR_WIDTH;

  typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;
  typedef enum logic {SRC_ALU, SRC_LSU} src_t;

  buf_state_t            r_buf_state;
  logic [ADDR_WIDTH-1:0] r_buf_rd;
  logic [DATA_WIDTH-1:0] r_buf_data;
  logic                  r_wen;
  logic [ADDR_WIDTH-1:0] r_rd;
  logic [DATA_WIDTH-1:0] r_data;
  src_t                  r_src;
  logic [31:0]           r_wb_count;
  logic [NREG-1:0]       r_busy;

  logic w_lsu_ready;
  logic w_accept;

  assign w_lsu_ready = !rst && ((r_buf_state == BUF_EMPTY) || !bus.alu_valid);
  assign w_accept    = bus.lsu_valid && w_lsu_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_state <= BUF_EMPTY;
      r_buf_rd    <= '0;
      r_buf_data  <= '0;
      r_wen       <= 1'b0;
      r_rd        <= '0;
      r_data      <= '0;
      r_src       <= SRC_ALU;
      r_wb_count  <= '0;
      r_busy      <= '0;
    end else begin
      if (bus.alu_valid) begin
        r_wen  <= (bus.alu_rd != '0);
        r_rd   <= bus.alu_rd;
        r_data <= bus.alu_data;
        r_src  <= SRC_ALU;
      end else if (r_buf_state == BUF_FULL) begin
        r_wen       <= (r_buf_rd != '0);
        r_rd        <= r_buf_rd;
        r_data      <= r_buf_data;
        r_src       <= SRC_LSU;
        r_buf_state <= BUF_EMPTY;
      end else begin
        r_wen <= 1'b0;
      end

      // A same-edge accept overrides the drain above, so the buffer stays full with the new entry.
      if (w_accept) begin
        r_buf_state <= BUF_FULL;
        r_buf_rd    <= bus.lsu_rd;
        r_buf_data  <= bus.lsu_data;
      end

      if (r_wen)
        r_wb_count <= r_wb_count + 32'd1;

      // Clear precedes set so a newly issued producer to the same index keeps the bit.
      if (r_wen && (r_src == SRC_LSU))
        r_busy[r_rd] <= 1'b0;
      if (bus.iss_valid && (bus.iss_rd != '0))
        r_busy[bus.iss_rd] <= 1'b1;
    end
  end

  assign bus.lsu_ready = w_lsu_ready;
  assign bus.rs1_busy  = r_busy[bus.rs1];
  assign bus.rs2_busy  = r_busy[bus.rs2];
  assign bus.rf_wen    = r_wen;
  assign bus.rf_rd     = r_rd;
  assign bus.rf_dataD  = r_data;
  assign bus.wb_count  = r_wb_count;
endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: directed scenarios with literal expectations plus a randomized
// phase, all continuously compared against a queue-based model of the write stage.
module tb_regfile_writeback;
  logic clk;
  logic rst;
  int unsigned total;
  int unsigned bad;

  regfile_writeback_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  regfile_writeback #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } entry_t;

  entry_t      m_buf[$];
  bit          m_busy[32];
  bit          m_wen;
  bit          m_from_lsu;
  logic [4:0]  m_rd;
  logic [31:0] m_data;
  logic [31:0] m_cnt;
  bit          m_valid;

  function automatic bit exp_ready();
    return !rst && !(m_buf.size() != 0 && bus.alu_valid);
  endfunction

  task automatic model_edge();
    entry_t e;
    bit acc;
    if (rst) begin
      m_buf.delete();
      foreach (m_busy[i]) m_busy[i] = 1'b0;
      m_wen = 0; m_from_lsu = 0; m_rd = '0; m_data = '0; m_cnt = '0;
      m_valid = 1;
      return;
    end
    if (!m_valid) return;
    acc = bus.lsu_valid && exp_ready();
    if (m_wen) m_cnt = m_cnt + 32'd1;
    if (m_wen && m_from_lsu) m_busy[m_rd] = 1'b0;
    if (bus.iss_valid && bus.iss_rd != 0) m_busy[bus.iss_rd] = 1'b1;
    if (bus.alu_valid) begin
      m_wen = (bus.alu_rd != 0); m_rd = bus.alu_rd; m_data = bus.alu_data; m_from_lsu = 0;
    end else if (m_buf.size() != 0) begin
      e = m_buf.pop_front();
      m_wen = (e.rd != 0); m_rd = e.rd; m_data = e.data; m_from_lsu = 1;
    end else begin
      m_wen = 0;
    end
    if (acc) begin
      e.rd = bus.lsu_rd; e.data = bus.lsu_data;
      m_buf.push_back(e);
    end
  endtask

  initial begin
    m_valid = 0;
    forever begin
      @(posedge clk);
      model_edge();
      @(negedge clk);
      if (rst || m_valid) chk("lsu_ready", {63'd0, bus.lsu_ready}, {63'd0, exp_ready()});
      if (m_valid) begin
        chk("rf_wen",   {63'd0, bus.rf_wen},   {63'd0, m_wen});
        chk("rf_rd",    {59'd0, bus.rf_rd},    {59'd0, m_rd});
        chk("rf_dataD", {32'd0, bus.rf_dataD}, {32'd0, m_data});
        chk("wb_count", {32'd0, bus.wb_count}, {32'd0, m_cnt});
        chk("rs1_busy", {63'd0, bus.rs1_busy}, {63'd0, m_busy[bus.rs1]});
        chk("rs2_busy", {63'd0, bus.rs2_busy}, {63'd0, m_busy[bus.rs2]});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    bus.alu_valid = 0;
    bus.lsu_valid = 0;
    bus.iss_valid = 0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] d);
    bus.alu_valid = 1; bus.alu_rd = rd; bus.alu_data = d;
  endtask

  task automatic lsu(input logic [4:0] rd, input logic [31:0] d);
    bus.lsu_valid = 1; bus.lsu_rd = rd; bus.lsu_data = d;
  endtask

  task automatic iss(input logic [4:0] rd);
    bus.iss_valid = 1; bus.iss_rd = rd;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1;
    bus.alu_valid = 1; bus.alu_rd = 5'd2; bus.alu_data = 32'h22;
    bus.lsu_valid = 1; bus.lsu_rd = 5'd3; bus.lsu_data = 32'h33;
    bus.iss_valid = 1; bus.iss_rd = 5'd7;
    bus.rs1 = 5'd7; bus.rs2 = 5'd9;

    // Reset held for two cycles with traffic offered
    @(negedge clk);
    chk("rst_wen", {63'd0, bus.rf_wen}, 64'd0);
    chk("rst_ready", {63'd0, bus.lsu_ready}, 64'd0);
    cyc(); alu(5'd2, 32'h22); lsu(5'd3, 32'h33); iss(5'd7);
    @(negedge clk);
    chk("rst_wen2", {63'd0, bus.rf_wen}, 64'd0);
    chk("rst_ready2", {63'd0, bus.lsu_ready}, 64'd0);
    chk("rst_count", {32'd0, bus.wb_count}, 64'd0);
    cyc(); rst = 0;
    @(negedge clk);
    chk("post_rst_busy1", {63'd0, bus.rs1_busy}, 64'd0);
    chk("post_rst_busy2", {63'd0, bus.rs2_busy}, 64'd0);

    // ALU path and x0 write
    cyc(); alu(5'd3, 32'hDEADBEEF);
    cyc(); alu(5'd0, 32'h55);
    @(negedge clk);
    chk("alu_wen", {63'd0, bus.rf_wen}, 64'd1);
    chk("alu_rd", {59'd0, bus.rf_rd}, 64'd3);
    chk("alu_data", {32'd0, bus.rf_dataD}, 64'hDEADBEEF);
    cyc();
    @(negedge clk);
    chk("x0_wen", {63'd0, bus.rf_wen}, 64'd0);
    chk("alu_count", {32'd0, bus.wb_count}, 64'd1);
    cyc();
    @(negedge clk);
    chk("x0_count", {32'd0, bus.wb_count}, 64'd1);

    // LSU issue, scoreboard set, retire and clear
    cyc(); iss(5'd7); bus.rs1 = 5'd7;
    cyc();
    @(negedge clk);
    chk("busy7_set", {63'd0, bus.rs1_busy}, 64'd1);
    cyc(); lsu(5'd7, 32'h1234);
    @(negedge clk);
    chk("lsu_ready_idle", {63'd0, bus.lsu_ready}, 64'd1);
    cyc();
    @(negedge clk);
    chk("lsu_lat_n1", {63'd0, bus.rf_wen}, 64'd0);
    cyc();
    @(negedge clk);
    chk("lsu_wen", {63'd0, bus.rf_wen}, 64'd1);
    chk("lsu_rd", {59'd0, bus.rf_rd}, 64'd7);
    chk("lsu_data", {32'd0, bus.rf_dataD}, 64'h1234);
    chk("busy7_during", {63'd0, bus.rs1_busy}, 64'd1);
    cyc();
    @(negedge clk);
    chk("busy7_clear", {63'd0, bus.rs1_busy}, 64'd0);
    chk("lsu_count", {32'd0, bus.wb_count}, 64'd2);

    // Collision: buffered rd=4 waits behind three ALU writes
    cyc(); lsu(5'd4, 32'hA);
    cyc(); alu(5'd1, 32'h11); lsu(5'd6, 32'h66);
    @(negedge clk);
    chk("coll_ready1", {63'd0, bus.lsu_ready}, 64'd0);
    cyc(); alu(5'd2, 32'h22); lsu(5'd6, 32'h66);
    @(negedge clk);
    chk("coll_ready2", {63'd0, bus.lsu_ready}, 64'd0);
    chk("coll_w1", {59'd0, bus.rf_rd}, 64'd1);
    cyc(); alu(5'd3, 32'h33); lsu(5'd6, 32'h66);
    @(negedge clk);
    chk("coll_ready3", {63'd0, bus.lsu_ready}, 64'd0);
    chk("coll_w2", {59'd0, bus.rf_rd}, 64'd2);
    cyc();
    @(negedge clk);
    chk("coll_w3", {59'd0, bus.rf_rd}, 64'd3);
    cyc();
    @(negedge clk);
    chk("coll_w4_rd", {59'd0, bus.rf_rd}, 64'd4);
    chk("coll_w4_data", {32'd0, bus.rf_dataD}, 64'hA);
    chk("coll_w4_wen", {63'd0, bus.rf_wen}, 64'd1);
    cyc();
    @(negedge clk);
    chk("coll_empty", {63'd0, bus.rf_wen}, 64'd0);

    // Same-edge clear and re-issue of rd=9
    cyc(); iss(5'd9);
    cyc(); lsu(5'd9, 32'h99); bus.rs1 = 5'd9;
    @(negedge clk);
    chk("busy9_set", {63'd0, bus.rs1_busy}, 64'd1);
    cyc();
    cyc(); iss(5'd9);
    @(negedge clk);
    chk("busy9_retire", {59'd0, bus.rf_rd}, 64'd9);
    cyc();
    @(negedge clk);
    chk("busy9_kept", {63'd0, bus.rs1_busy}, 64'd1);

    // Mid-operation reset with full buffer and busy[5]
    cyc(); iss(5'd5); bus.rs1 = 5'd5;
    cyc(); lsu(5'd5, 32'h77);
    cyc(); rst = 1;
    @(negedge clk);
    chk("mid_rst_ready", {63'd0, bus.lsu_ready}, 64'd0);
    cyc(); rst = 0;
    @(negedge clk);
    chk("mid_ready", {63'd0, bus.lsu_ready}, 64'd1);
    chk("mid_wen", {63'd0, bus.rf_wen}, 64'd0);
    chk("mid_busy5", {63'd0, bus.rs1_busy}, 64'd0);
    cyc();
    @(negedge clk);
    chk("mid_wen2", {63'd0, bus.rf_wen}, 64'd0);

    // Randomized traffic; small index range provokes hazards and collisions
    for (int n = 0; n < 3000; n++) begin
      cyc();
      rst = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 1) == 1) alu(5'($urandom_range(0, 12)), $urandom);
      if ($urandom_range(0, 1) == 1) lsu(5'($urandom_range(0, 12)), $urandom);
      if ($urandom_range(0, 2) == 0) iss(5'($urandom_range(0, 12)));
      bus.rs1 = 5'($urandom_range(0, 15));
      bus.rs2 = 5'($urandom_range(0, 31));
    end
    cyc(); rst = 0;
    repeat (4) cyc();
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
